drop_sequencer: RTL
===================

# drop_sequencer

Frame-paced controller that sequences the falling-rectangle datapath for the stacking game. It owns the rectangle position registers (`xpos`, `ypos`) that the rectangle drawer consumes. Before a drop the rectangle tracks the mouse; a left click releases it under gravity, and it lands either on the floor or on the stack already built. The block tracks stack height, spawns the next rectangle, and reports when the stack is full.

## Interface
Parameters:
- `FLOOR_Y`, 534: `ypos` at which the first rectangle rests (top edge).
- `RECT_H`, 66: rectangle height; each landed block raises the landing line by this amount.
- `X_MAX`, 736: largest legal `xpos`; mouse x is clamped to this value.
- `G`, 1: velocity increment per frame, in px/frame.
- `V_MAX`, 32: velocity ceiling, in px/frame.
- `HOLD_FRAMES`, 2: frames the landed block is held before respawn.
- `MAX_BLOCKS`, 8: stack capacity. `FLOOR_Y >= RECT_H*(MAX_BLOCKS-1)` is required.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame (vblank start).
- `mouse_left` in 1: left button level, already synchronous to `clk`.
- `mouse_xpos` in 12: mouse x.
- `mouse_ypos` in 12: mouse y. Unused by the motion logic; present for interface compatibility.
- `xpos` out 12: rectangle x.
- `ypos` out 12: rectangle y.
- `busy` out 1: high in FALL, LAND and HOLD.
- `landed` out 1: one-cycle pulse when a block comes to rest.
- `block_cnt` out 4: number of landed blocks.
- `stack_full` out 1: high in FULL.

## Operation
- All outputs are registered. Reset values: `xpos`=0, `ypos`=0, `busy`=0, `landed`=0, `block_cnt`=0, `stack_full`=0. Reset also clears the internal velocity `vel`, the hold counter and the click edge register, and puts the FSM in FOLLOW.
- `land_y` = `FLOOR_Y` − `RECT_H`·`block_cnt`, computed at 12 bits.
- A click is the rising edge of `mouse_left`, detected with a 1-cycle registered copy of the input. Holding the button down produces exactly one click.
- States:
  - FOLLOW: each cycle, `xpos` ← min(`mouse_xpos`, `X_MAX`) and `ypos` ← 0.
    - On a click: latch the current clamped x (x freezes), set `vel` ← 0, go to FALL.
  - FALL: on each `frame_tick`:
    - `vel` ← min(`vel`+`G`, `V_MAX`).
    - `ny` = `ypos` + new `vel`, computed at 13 bits so it cannot wrap.
    - If `ny` ≥ `land_y`: `ypos` ← `land_y`, go to LAND. Otherwise `ypos` ← `ny`.
    - Clicks are ignored in this state.
  - LAND: lasts one cycle.
    - `landed`=1, `block_cnt` increments, hold counter is cleared.
    - Go to FULL if the new count equals `MAX_BLOCKS`, otherwise to HOLD.
  - HOLD: `xpos` and `ypos` are held. The hold counter advances on each `frame_tick`. After `HOLD_FRAMES` ticks, go to FOLLOW. Clicks are ignored.
  - FULL: `stack_full`=1 and positions are held. Only `rst` leaves this state.
- Simultaneous events:
  - Click and `frame_tick` in the same FOLLOW cycle: the FSM enters FALL, and that tick does not move the block. The first step happens on the next tick.
  - `frame_tick` in the LAND cycle is ignored.
- Reset mid-operation (any state): all outputs return to their reset values asynchronously. The stack is cleared.

## Timing
- FOLLOW: `xpos` reflects `mouse_xpos` 1 cycle later.
- Click to FALL: `busy` rises 1 cycle after the `mouse_left` rising edge is sampled.
- FALL step: `ypos` and `vel` update in the cycle after the `frame_tick` cycle.
- `landed` is asserted in the cycle after the landing tick is registered, i.e. 1 cycle after `ypos` reaches `land_y`. `block_cnt` updates in that same cycle.
- Respawn: FOLLOW is entered 1 cycle after the `HOLD_FRAMES`-th tick in HOLD. `busy` falls in that same cycle.

## Test plan
- Reset/follow: release `rst`, drive `mouse_xpos`=200 → `xpos`=200, `ypos`=0, `busy`=0. Then drive `mouse_xpos`=790 → `xpos`=736.
- First drop: click at x=200, then apply ticks.
  - Required `ypos` sequence: 1, 3, 6, 10, …, 528 (tick 32), then 534 (tick 33).
  - `landed` pulses once, `block_cnt`=1, `xpos` stays at 200 throughout.
- Stacked drop: after the hold, apply a second click.
  - `ypos` reaches 465 on tick 30 and is clamped to 468 on tick 31.
  - `block_cnt`=2.
- Button held and clicked during FALL: keep `mouse_left`=1 for 21 cycles → exactly one drop. Extra clicks during FALL or HOLD → no state change and no extra `landed` pulse.
- Click coincident with `frame_tick` → `ypos` stays 0 on that tick and is 1 after the next tick.
- Capacity and reset:
  - Perform 8 drops → `stack_full`=1 and further clicks are ignored.
  - Assert `rst` mid-FALL of any drop → all outputs are 0 and the FSM returns to FOLLOW.

Source files
------------

// File: rtl/drop_sequencer.sv
// drop_sequencer: frame-paced controller for the falling rectangle of the
// stacking game. The rectangle follows the mouse and drops on a click. It
// lands on the floor or on top of the stack, and after a short hold a new
// rectangle spawns. Once the stack is full, only reset restarts the game.
module drop_sequencer #(
    parameter int FLOOR_Y     = 534,
    parameter int RECT_H      = 66,
    parameter int X_MAX       = 736,
    parameter int G           = 1,
    parameter int V_MAX       = 32,
    parameter int HOLD_FRAMES = 2,
    parameter int MAX_BLOCKS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy,
    output logic        landed,
    output logic [3:0]  block_cnt,
    output logic        stack_full
);

    typedef enum logic [2:0] {
        FOLLOW,
        FALL,
        LAND,
        HOLD,
        FULL
    } state_t;

    localparam logic [11:0] FLOOR_Y12 = 12'(FLOOR_Y);
    localparam logic [11:0] RECT_H12  = 12'(RECT_H);
    localparam logic [11:0] X_MAX12   = 12'(X_MAX);
    localparam logic [11:0] V_MAX12   = 12'(V_MAX);
    localparam int          HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    state_t        state;
    state_t        state_n;
    logic          mouse_left_q;
    logic          click;
    logic [11:0]   vel;
    logic [11:0]   vel_n;
    logic [11:0]   vel_step;
    logic [12:0]   vel_sum;
    logic [12:0]   ny;
    logic [11:0]   land_y;
    logic [11:0]   x_clamped;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic [11:0]   xpos_n;
    logic [11:0]   ypos_n;
    logic [3:0]    cnt_n;
    logic          landed_n;

    // Mouse y is part of the interface but plays no role in the motion.
    logic unused_mouse_y;
    assign unused_mouse_y = ^mouse_ypos;

    assign click     = mouse_left & ~mouse_left_q;
    assign x_clamped = (mouse_xpos > X_MAX12) ? X_MAX12 : mouse_xpos;
    assign land_y    = FLOOR_Y12 - RECT_H12 * {8'd0, block_cnt};
    assign vel_sum   = {1'b0, vel} + 13'(G);
    assign vel_step  = (vel_sum > {1'b0, V_MAX12}) ? V_MAX12 : vel_sum[11:0];
    assign ny        = {1'b0, ypos} + {1'b0, vel_step};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FOLLOW;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next values of every register the controller owns.
    always_comb begin
        state_n  = state;
        xpos_n   = xpos;
        ypos_n   = ypos;
        vel_n    = vel;
        hold_n   = hold_cnt;
        cnt_n    = block_cnt;
        landed_n = 1'b0;
        case (state)
            FOLLOW: begin
                xpos_n = x_clamped;
                ypos_n = 12'd0;
                if (click) begin
                    vel_n   = 12'd0;
                    state_n = FALL;
                end
            end
            FALL: begin
                if (frame_tick) begin
                    vel_n = vel_step;
                    if (ny >= {1'b0, land_y}) begin
                        ypos_n  = land_y;
                        state_n = LAND;
                    end else begin
                        ypos_n = ny[11:0];
                    end
                end
            end
            LAND: begin
                landed_n = 1'b1;
                cnt_n    = block_cnt + 4'd1;
                hold_n   = '0;
                state_n  = (cnt_n == 4'(MAX_BLOCKS)) ? FULL : HOLD;
            end
            HOLD: begin
                if (frame_tick) begin
                    hold_n = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = FOLLOW;
                    end
                end
            end
            FULL: begin
            end
            default: begin
                state_n = FOLLOW;
            end
        endcase
    end

    // Datapath and output registers; busy/stack_full follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mouse_left_q <= 1'b0;
            vel          <= 12'd0;
            hold_cnt     <= '0;
            xpos         <= 12'd0;
            ypos         <= 12'd0;
            busy         <= 1'b0;
            landed       <= 1'b0;
            block_cnt    <= 4'd0;
            stack_full   <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
            vel          <= vel_n;
            hold_cnt     <= hold_n;
            xpos         <= xpos_n;
            ypos         <= ypos_n;
            busy         <= (state_n == FALL) || (state_n == LAND) || (state_n == HOLD);
            landed       <= landed_n;
            block_cnt    <= cnt_n;
            stack_full   <= (state_n == FULL);
        end
    end

endmodule
